// File: rtl/bpsk_rx_if.sv
// Sample-stream and decision bundle of the coherent BPSK demodulator.
// The master drives the samples and the slave returns the bit, byte and lock status.
interface bpsk_rx_if;
  logic               en;
  logic signed [15:0] sample;
  logic               bit_out;
  logic               bit_valid;
  logic [7:0]         byte_out;
  logic               byte_valid;
  logic               locked;
  logic               lost;

  modport master (
    output en, sample,
    input  bit_out, bit_valid, byte_out, byte_valid, locked, lost
  );

  modport slave (
    input  en, sample,
    output bit_out, bit_valid, byte_out, byte_valid, locked, lost
  );
endinterface

// File: rtl/bpsk_rx.sv
// Coherent BPSK demodulator. It locks its phase on the first strong sample and runs an
// integrate-and-dump correlator against a square-wave reference, then packs the hard decisions MSB-first into bytes.
module bpsk_rx #(
  parameter int SAMPLES_PER_CYCLE = 32,
  parameter int CYCLES_PER_BIT    = 4,
  parameter int PHASE_OFS         = 1,
  parameter int DET_THRESH        = 2048,
  parameter int LOSS_THRESH       = 4096,
  parameter int ACC_W             = 24
) (
  input logic      clk,
  input logic      rst,
  bpsk_rx_if.slave bus
);
  localparam int N  = SAMPLES_PER_CYCLE;
  localparam int PW = $clog2(N);
  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

  localparam logic [PW-1:0] PH_ACQ   = PW'(PHASE_OFS);
  localparam logic [PW-1:0] PH_NEXT  = PW'((PHASE_OFS + 1) % N);
  localparam logic [PW-1:0] PH_LAST  = PW'((PHASE_OFS + N - 1) % N);
  localparam logic [PW-1:0] PH_MAX   = PW'(N - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(N / 2);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [16:0]   DET      = 17'(DET_THRESH);
  localparam logic signed [ACC_W-1:0] LOSS = ACC_W'(LOSS_THRESH);

  typedef enum logic [0:0] {IDLE = 1'b0, TRACK = 1'b1} state_t;

  // Sign-extended sample, negated in the lower half of the carrier cycle (reference = -1).
  function automatic logic signed [ACC_W-1:0] contrib(input logic signed [15:0] s,
                                                      input logic [PW-1:0] ph);
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-16){s[15]}}, s};
    return (ph >= PH_HALF) ? -ext : ext;
  endfunction

  state_t                  state_r;
  logic [PW-1:0]           phase_r;
  logic [CW-1:0]           cycle_r;
  logic [2:0]              bit_cnt_r;
  logic [7:0]              shreg_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    bit_out_r, bit_valid_r, byte_valid_r, locked_r, lost_r;
  logic [7:0]              byte_out_r;

  logic [16:0]             sample_mag_s;
  logic                    detect_s;
  logic [PW-1:0]           phase_sel_s;
  logic [PW-1:0]           phase_inc_s;
  logic signed [ACC_W-1:0] acc_base_s;
  logic signed [ACC_W-1:0] acc_next_s;
  logic signed [ACC_W-1:0] acc_mag_s;
  logic                    weak_s;
  logic                    end_bit_s;
  logic                    bit_s;
  logic [7:0]              shift_s;

  // Correlator datapath and the detection, end-of-window and decision terms.
  always_comb begin
    // 17 bits so that -32768 yields 32768
    sample_mag_s = bus.sample[15] ? (17'd0 - {1'b1, bus.sample}) : {1'b0, bus.sample};
    detect_s     = (sample_mag_s > DET);
    phase_sel_s  = (state_r == TRACK) ? phase_r : PH_ACQ;
    phase_inc_s  = (phase_r == PH_MAX) ? {PW{1'b0}} : (phase_r + PH_ONE);
    acc_base_s   = (state_r == TRACK) ? acc_r : {ACC_W{1'b0}};
    acc_next_s   = acc_base_s + contrib(bus.sample, phase_sel_s);
    acc_mag_s    = acc_next_s[ACC_W-1] ? -acc_next_s : acc_next_s;
    weak_s       = (acc_mag_s < LOSS);
    // Cycles are counted from the acquisition phase, so a window is exactly N*CYCLES_PER_BIT samples.
    end_bit_s    = (phase_r == PH_LAST) && (cycle_r == CYC_LAST);
    bit_s        = acc_next_s[ACC_W-1];
    shift_s      = {shreg_r[6:0], bit_s};
  end

  // Acquisition/track state machine with registered decision and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      phase_r      <= {PW{1'b0}};
      cycle_r      <= {CW{1'b0}};
      bit_cnt_r    <= 3'd0;
      shreg_r      <= 8'd0;
      acc_r        <= {ACC_W{1'b0}};
      bit_out_r    <= 1'b0;
      bit_valid_r  <= 1'b0;
      byte_out_r   <= 8'd0;
      byte_valid_r <= 1'b0;
      locked_r     <= 1'b0;
      lost_r       <= 1'b0;
    end else begin
      bit_valid_r  <= 1'b0;
      byte_valid_r <= 1'b0;
      lost_r       <= 1'b0;
      if (bus.en) begin
        case (state_r)
          IDLE: begin
            if (detect_s) begin
              acc_r     <= acc_next_s;
              phase_r   <= PH_NEXT;
              cycle_r   <= {CW{1'b0}};
              bit_cnt_r <= 3'd0;
              shreg_r   <= 8'd0;
              locked_r  <= 1'b1;
              state_r   <= TRACK;
            end else begin
              acc_r <= {ACC_W{1'b0}};
            end
          end
          TRACK: begin
            phase_r <= phase_inc_s;
            if (end_bit_s) begin
              acc_r   <= {ACC_W{1'b0}};
              cycle_r <= {CW{1'b0}};
              if (weak_s) begin
                lost_r    <= 1'b1;
                locked_r  <= 1'b0;
                bit_cnt_r <= 3'd0;
                shreg_r   <= 8'd0;
                state_r   <= IDLE;
              end else begin
                bit_out_r   <= bit_s;
                bit_valid_r <= 1'b1;
                shreg_r     <= shift_s;
                bit_cnt_r   <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                  byte_out_r   <= shift_s;
                  byte_valid_r <= 1'b1;
                end else begin
                  byte_valid_r <= 1'b0;
                end
              end
            end else begin
              acc_r <= acc_next_s;
              if (phase_r == PH_LAST) begin
                cycle_r <= cycle_r + CYC_ONE;
              end else begin
                cycle_r <= cycle_r;
              end
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.bit_out    = bit_out_r;
  assign bus.bit_valid  = bit_valid_r;
  assign bus.byte_out   = byte_out_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.locked     = locked_r;
  assign bus.lost       = lost_r;
endmodule

// File: tb/tb_bpsk_rx.sv
// Self-checking bench for bpsk_rx. A sample-stream reference model sets the expected outputs for every cycle.
// Each scenario task compares the DUT against that model and against fixed values.
module tb_bpsk_rx;
  localparam int N     = 32;
  localparam int CPB   = 4;
  localparam int WIN   = N * CPB;
  localparam int OFS   = 1;
  localparam int DET   = 2048;
  localparam int LOSS  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bpsk_rx_if bus ();

  bpsk_rx dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;
  real sin_tab[N];
  logic signed [15:0] tx[$];

  // reference model state: window position k counts samples since the acquisition sample
  bit      m_track;
  int      m_k;
  longint  m_acc;
  int      m_nbits;
  bit [7:0] m_byte;
  bit      exp_locked, exp_lost, exp_bv, exp_byv, exp_bit;
  bit [7:0] exp_byte;

  function automatic int ref_sign(input int k);
    return (((OFS + k) % N) < N / 2) ? 1 : -1;
  endfunction

  task automatic model_reset();
    m_track = 0; m_k = 0; m_acc = 0; m_nbits = 0; m_byte = 8'd0;
    exp_locked = 0; exp_lost = 0; exp_bv = 0; exp_byv = 0; exp_bit = 0; exp_byte = 8'd0;
  endtask

  task automatic model_en(input int s);
    longint mag;
    if (!m_track) begin
      if (((s < 0) ? -s : s) > DET) begin
        m_track = 1; m_acc = longint'(ref_sign(0) * s); m_k = 1;
        m_nbits = 0; m_byte = 8'd0; exp_locked = 1;
      end
    end else begin
      m_acc = m_acc + longint'(ref_sign(m_k) * s);
      if (m_k == WIN - 1) begin
        mag = (m_acc < 0) ? -m_acc : m_acc;
        if (mag < LOSS) begin
          exp_lost = 1; exp_locked = 0; m_track = 0;
        end else begin
          exp_bit = (m_acc < 0);
          exp_bv  = 1;
          m_byte  = {m_byte[6:0], exp_bit};
          m_nbits = m_nbits + 1;
          if (m_nbits == 8) begin
            exp_byte = m_byte; exp_byv = 1; m_nbits = 0;
          end
        end
        m_acc = 0; m_k = 0;
      end else begin
        m_k = m_k + 1;
      end
    end
  endtask

  function automatic logic [12:0] obs_vec();
    return {bus.locked, bus.lost, bus.bit_valid, bus.byte_valid, bus.bit_out, bus.byte_out};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {exp_locked, exp_lost, exp_bv, exp_byv, exp_bit, exp_byte};
  endfunction

  // one clock: drive inputs, advance across the edge, update the model
  task automatic step(input logic e, input logic signed [15:0] s);
    bus.en = e; bus.sample = s;
    @(posedge clk); #1;
    cyc++;
    exp_bv = 0; exp_byv = 0; exp_lost = 0;
    if (rst) model_reset();
    else if (e) model_en(int'(s));
  endtask

  function automatic logic signed [15:0] clamp16(input int v);
    if (v > 32767) return 16'sd32767;
    if (v < -32768) return -16'sd32768;
    return 16'(v);
  endfunction

  // transmitter-like burst: one 4-cycle sine window per bit, inverted for 1, MSB first
  task automatic build_burst(input logic [7:0] data, input int nbits, input real amp, input int noise);
    int v;
    for (int b = 0; b < nbits; b++) begin
      for (int j = 0; j < WIN; j++) begin
        v = $rtoi($floor(amp * sin_tab[j % N] + 0.5));
        if (data[7 - b]) v = -v;
        if (noise > 0) v = v + int'($urandom_range(0, 2 * noise)) - noise;
        tx.push_back(clamp16(v));
      end
    end
  endtask

  task automatic add_zeros(input int n);
    for (int i = 0; i < n; i++) tx.push_back(16'sd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step(1'b0, 16'sd0);
    rst = 1'b0;
    compared++;
    if (obs_vec() !== 13'd0) begin
      mismatched++; $display("FAIL reset_values got=%h want=%h", obs_vec(), 13'd0);
    end
    for (int i = 0; i < 200; i++) begin
      step(1'b1, ($urandom_range(0, 1) != 0) ? 16'sd1000 : -16'sd1000);
      compared++;
      if (obs_vec() !== 13'd0) begin
        mismatched++; $display("FAIL idle_low_amp cyc=%0d got=%h want=%h", cyc, obs_vec(), 13'd0);
      end
    end
  endtask

  task automatic test_clean_byte();
    int last_bv = -1; int nbv = 0; int nbyv = 0;
    tx.delete(); build_burst(8'hB2, 8, 16000.0, 0); add_zeros(200);
    foreach (tx[i]) begin
      step(1'b1, tx[i]);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL clean cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (bus.byte_valid) nbyv++;
      if (bus.bit_valid) begin
        nbv++;
        if (last_bv >= 0) begin
          compared++;
          if (cyc - last_bv != WIN) begin
            mismatched++; $display("FAIL clean_spacing got=%0d want=%0d", cyc - last_bv, WIN);
          end
        end
        last_bv = cyc;
      end
    end
    compared++;
    if (bus.byte_out !== 8'hB2) begin
      mismatched++; $display("FAIL clean_byte got=%h want=b2", bus.byte_out);
    end
    compared++;
    if (nbv != 8 || nbyv != 1) begin
      mismatched++; $display("FAIL clean_counts bits=%0d bytes=%0d want 8/1", nbv, nbyv);
    end
  endtask

  task automatic test_gapped_en();
    int last_bv = -1;
    tx.delete(); build_burst(8'hB2, 8, 16000.0, 0); add_zeros(200);
    foreach (tx[i]) begin
      for (int g = 0; g < 3; g++) begin
        step(g == 0, (g == 0) ? tx[i] : 16'($urandom));
        compared++;
        if (obs_vec() !== exp_vec()) begin
          mismatched++; $display("FAIL gapped cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
        end
        if (bus.bit_valid) begin
          if (last_bv >= 0) begin
            compared++;
            if (cyc - last_bv != 3 * WIN) begin
              mismatched++; $display("FAIL gapped_spacing got=%0d want=%0d", cyc - last_bv, 3 * WIN);
            end
          end
          last_bv = cyc;
        end
      end
    end
    compared++;
    if (bus.byte_out !== 8'hB2) begin
      mismatched++; $display("FAIL gapped_byte got=%h want=b2", bus.byte_out);
    end
  endtask

  task automatic test_carrier_loss();
    int nlost = 0; int nbyv = 0;
    logic [7:0] data;
    tx.delete(); build_burst(8'hA5, 3, 16000.0, 100); add_zeros(200);
    foreach (tx[i]) begin
      step(1'b1, tx[i]);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL loss cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (bus.lost) nlost++;
      if (bus.byte_valid) nbyv++;
    end
    compared++;
    if (nlost != 1 || nbyv != 0 || bus.locked !== 1'b0) begin
      mismatched++; $display("FAIL loss_summary lost=%0d bytes=%0d locked=%b want 1/0/0", nlost, nbyv, bus.locked);
    end
    data = 8'($urandom_range(1, 254));
    tx.delete(); build_burst(data, 8, 16000.0, 100); add_zeros(200);
    foreach (tx[i]) begin
      step(1'b1, tx[i]);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL relock cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    compared++;
    if (bus.byte_out !== data) begin
      mismatched++; $display("FAIL relock_byte got=%h want=%h", bus.byte_out, data);
    end
  endtask

  task automatic test_extremes();
    tx.delete();
    for (int j = 0; j < 8 * WIN; j++) tx.push_back(((j % N) < N / 2) ? 16'sd32767 : -16'sd32768);
    add_zeros(200);
    foreach (tx[i]) begin
      step(1'b1, tx[i]);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL extremes cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (bus.bit_valid) begin
        compared++;
        if (bus.bit_out !== 1'b0) begin
          mismatched++; $display("FAIL extremes_bit got=%b want=0", bus.bit_out);
        end
      end
    end
    compared++;
    if (bus.byte_out !== 8'h00) begin
      mismatched++; $display("FAIL extremes_byte got=%h want=00", bus.byte_out);
    end
  endtask

  task automatic test_mid_byte_reset();
    logic [7:0] data;
    tx.delete(); build_burst(8'h5C, 8, 16000.0, 0);
    for (int i = 0; i < 4 * WIN + 60; i++) begin
      step(1'b1, tx[i]);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL pre_reset cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    rst = 1'b1;
    step(1'b1, tx[4 * WIN + 60]);
    rst = 1'b0;
    compared++;
    if (obs_vec() !== 13'd0) begin
      mismatched++; $display("FAIL mid_reset got=%h want=%h", obs_vec(), 13'd0);
    end
    data = 8'($urandom_range(1, 254));
    tx.delete(); add_zeros(50); build_burst(data, 8, 16000.0, 200); add_zeros(200);
    foreach (tx[i]) begin
      step(1'b1, tx[i]);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    compared++;
    if (bus.byte_out !== data) begin
      mismatched++; $display("FAIL post_reset_byte got=%h want=%h", bus.byte_out, data);
    end
  endtask

  task automatic test_random();
    logic e;
    for (int r = 0; r < 3; r++) begin
      tx.delete();
      build_burst(8'($urandom), 8, 16000.0, 500);
      build_burst(8'($urandom), 8, 12000.0, 500);
      add_zeros(200);
      for (int i = 0; i < tx.size(); ) begin
        e = ($urandom_range(0, 3) != 0);
        step(e, e ? tx[i] : 16'($urandom));
        if (e) i++;
        compared++;
        if (obs_vec() !== exp_vec()) begin
          mismatched++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) sin_tab[i] = $sin(2.0 * 3.14159265358979 * real'(i) / real'(N));
    bus.en = 1'b0; bus.sample = 16'sd0;
    model_reset();
    test_reset();
    test_clean_byte();
    test_gapped_en();
    test_carrier_loss();
    test_extremes();
    test_mid_byte_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
